// File: rtl/dmem_pkg.sv
// Shared types and the address/range fault rule for the memory-stage data memory.
// Imported by the top-level unit.
package dmem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WIDE2 = 1'b1
  } state_t;

  typedef enum logic {
    ACC_RD = 1'b0,
    ACC_WR = 1'b1
  } acc_t;

  // addr arrives zero-extended to 64 bits, so any bit at or above depth_log2 is out of range.
  // A wide access at the last word would wrap to word 0, so it is rejected as well.
  function automatic logic range_fault(input logic [63:0] addr, input logic wide,
                                       input int unsigned depth_log2);
    logic [63:0] last_idx;
    last_idx = (64'd1 << depth_log2) - 64'd1;
    return ((addr >> depth_log2) != 64'd0) || (wide && ((addr & last_idx) == last_idx));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with one write enable and a registered read port.
// The read register only loads on a read, so it holds between reads.
module dmem_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // NOTE: the array and its read register have no reset so the storage maps onto block RAM;
  // contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_unit.sv
// Memory-stage data memory: single and big-endian two-word accesses, registered read
// with a valid strobe, busy during the second half of a wide access, fault on bad requests.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic                rd,
  input  logic                wr,
  input  logic                wide,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [2*DATA_W-1:0] rdata,
  output logic                rvalid,
  output logic                busy,
  output logic                fault
);

  state_t                state;
  acc_t                  dir_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_W-1:0]     wlo_q;
  logic [DATA_W-1:0]     hi_q;
  logic [DATA_W-1:0]     lo_q;
  logic                  sel_arr;

  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_w2;
  logic                  req_one;
  logic                  illegal;
  logic                  bad;
  logic                  accept;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  rd_done;
  logic                  arr_we;
  logic                  arr_re;
  logic [DEPTH_LOG2-1:0] arr_addr;
  logic [DATA_W-1:0]     arr_wdata;
  logic [DATA_W-1:0]     arr_rdata;
  logic [DATA_W-1:0]     lo_now;

  assign idx     = addr[DEPTH_LOG2-1:0];
  assign in_w2   = (state == WIDE2);
  assign busy    = in_w2;
  assign req_one = cs && !in_w2 && (rd ^ wr);
  assign illegal = cs && !in_w2 && rd && wr;
  assign bad     = req_one && range_fault(64'(addr), wide, DEPTH_LOG2);
  assign accept  = req_one && !bad;
  assign acc_rd  = accept && rd;
  assign acc_wr  = accept && wr;

  // The second half of a wide access runs from latched state; live inputs are ignored.
  assign arr_we    = acc_wr || (in_w2 && dir_q == ACC_WR);
  assign arr_re    = acc_rd || (in_w2 && dir_q == ACC_RD);
  assign arr_addr  = in_w2 ? idx_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1} : idx;
  assign arr_wdata = in_w2 ? wlo_q : (wide ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0]);
  assign rd_done   = (acc_rd && !wide) || (in_w2 && dir_q == ACC_RD);

  // The low half shows the RAM read register only right after a completed read, otherwise a
  // held copy, so the first word of a wide read never leaks onto rdata early.
  assign lo_now = sel_arr ? arr_rdata : lo_q;
  assign rdata  = {hi_q, lo_now};

  dmem_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .re   (arr_re),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  // NOTE: all state here is updated with non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dir_q   <= ACC_RD;
      idx_q   <= '0;
      wlo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sel_arr <= 1'b0;
      rvalid  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      fault   <= illegal || bad;
      rvalid  <= rd_done;
      sel_arr <= rd_done;
      lo_q    <= lo_now;

      if (acc_rd && !wide) hi_q <= '0;
      else if (in_w2 && dir_q == ACC_RD) hi_q <= arr_rdata;

      case (state)
        IDLE: begin
          if (accept && wide) begin
            state <= WIDE2;
            dir_q <= wr ? ACC_WR : ACC_RD;
            idx_q <= idx;
            wlo_q <= wdata[DATA_W-1:0];
          end
        end
        WIDE2:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
